// File: rtl/chess_ctrl.sv
// Two-player chess clock: three debounced buttons drive an IDLE/RUN_A/RUN_B/DONE
// controller that counts each player's remaining seconds down from INIT_SEC.
module chess_ctrl #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned INIT_SEC   = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_a,
  input  logic       btn_b,
  output logic       en,
  output logic       win,
  output logic [9:0] time_a,
  output logic [9:0] time_b,
  output logic [1:0] turn
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
  localparam logic [9:0]    INIT_T    = 10'(INIT_SEC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit order everywhere below: [0] start, [1] player A, [2] player B.
  logic [2:0]         raw_btn;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         db_lvl;
  logic [2:0]         armed;
  logic [2:0]         press;
  logic [1:0]         sync_fill;
  logic [2:0][DW-1:0] deb_cnt;

  assign raw_btn = {btn_b, btn_a, btn_start};

  // A button only becomes armed once it has been seen released after reset,
  // so a button held through reset release cannot produce a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      db_lvl    <= '0;
      armed     <= '0;
      press     <= '0;
      sync_fill <= '0;
      deb_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // which is what makes sync1 -> sync2 a real two-stage pipeline.
      sync1     <= raw_btn;
      sync2     <= sync1;
      sync_fill <= {sync_fill[0], 1'b1};
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync_fill[1] && !sync2[i]) begin
          armed[i] <= 1'b1;
        end
        if (sync2[i] != db_lvl[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            db_lvl[i]  <= sync2[i];
            deb_cnt[i] <= '0;
            press[i]   <= sync2[i] & armed[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;
  logic          start_p;
  logic          a_p;
  logic          b_p;

  assign start_p = press[0];
  assign a_p     = press[1];
  assign b_p     = press[2];
  // The prescaler sits at zero outside the running states, so tick is only ever seen there.
  assign tick    = (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      en     <= 1'b0;
      win    <= 1'b0;
      turn   <= 2'b00;
      time_a <= INIT_T;
      time_b <= INIT_T;
      presc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_p) begin
            state <= RUN_A;
            turn  <= 2'b01;
            presc <= '0;
          end
        end

        // Priority inside a running state: start, then timeout, then end-of-turn.
        RUN_A: begin
          if (start_p) begin
            state  <= IDLE;
            turn   <= 2'b00;
            presc  <= '0;
            time_a <= INIT_T;
            time_b <= INIT_T;
          end else if (tick && time_a <= 10'd1) begin
            state  <= DONE;
            turn   <= 2'b00;
            en     <= 1'b1;
            win    <= 1'b0;
            time_a <= '0;
            presc  <= '0;
          end else begin
            if (tick) begin
              time_a <= time_a - 10'd1;
            end
            if (a_p) begin
              state <= RUN_B;
              turn  <= 2'b10;
              presc <= '0;
            end else begin
              presc <= tick ? '0 : presc + PW'(1);
            end
          end
        end

        RUN_B: begin
          if (start_p) begin
            state  <= IDLE;
            turn   <= 2'b00;
            presc  <= '0;
            time_a <= INIT_T;
            time_b <= INIT_T;
          end else if (tick && time_b <= 10'd1) begin
            state  <= DONE;
            turn   <= 2'b00;
            en     <= 1'b1;
            win    <= 1'b1;
            time_b <= '0;
            presc  <= '0;
          end else begin
            if (tick) begin
              time_b <= time_b - 10'd1;
            end
            if (b_p) begin
              state <= RUN_A;
              turn  <= 2'b01;
              presc <= '0;
            end else begin
              presc <= tick ? '0 : presc + PW'(1);
            end
          end
        end

        DONE: begin
          if (start_p) begin
            state  <= IDLE;
            en     <= 1'b0;
            presc  <= '0;
            time_a <= INIT_T;
            time_b <= INIT_T;
          end
        end

        default: begin
          state <= IDLE;
          turn  <= 2'b00;
          en    <= 1'b0;
          presc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chess_ctrl.sv
// Bench for chess_ctrl: a window-based debounce model plus a game model are
// compared with the DUT every cycle, alongside hand-computed checkpoints.
module tb_chess_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int INIT     = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btns;
  logic       en;
  logic       win;
  logic [9:0] time_a;
  logic [9:0] time_b;
  logic [1:0] turn;

  always #5 clk = ~clk;

  chess_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .DEB_CYCLES(DEB),
    .INIT_SEC  (INIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_start(btns[0]),
    .btn_a    (btns[1]),
    .btn_b    (btns[2]),
    .en       (en),
    .win      (win),
    .time_a   (time_a),
    .time_b   (time_b),
    .turn     (turn)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 A running, 2 B running, 3 done.
  int       m_mode;
  int       m_ta;
  int       m_tb;
  int       m_el;
  bit       m_win;
  bit [2:0] m_db;
  bit [2:0] m_pulse;
  bit [2:0] m_arm;
  bit [2:0] hist [8];
  int       nsamp;

  always @(posedge clk or negedge rst_n) begin : model
    bit       ps, pa, pb, tick, all_diff;
    bit [2:0] nxt_pulse;
    if (!rst_n) begin
      m_mode  = 0;
      m_ta    = INIT;
      m_tb    = INIT;
      m_el    = 0;
      m_win   = 1'b0;
      m_db    = '0;
      m_pulse = '0;
      m_arm   = '0;
      nsamp   = 0;
      for (int j = 0; j < 8; j++) hist[j] = '0;
    end else begin
      ps = m_pulse[0];
      pa = m_pulse[1];
      pb = m_pulse[2];
      case (m_mode)
        0: if (ps) begin m_mode = 1; m_el = 0; end
        1, 2: begin
          if (ps) begin
            m_mode = 0; m_ta = INIT; m_tb = INIT;
          end else begin
            m_el++;
            tick = (m_el % TICK_DIV) == 0;
            if (m_mode == 1) begin
              if (tick) begin
                m_ta--;
                if (m_ta == 0) begin m_mode = 3; m_win = 1'b0; end
              end
              if (m_mode == 1 && pa) begin m_mode = 2; m_el = 0; end
            end else begin
              if (tick) begin
                m_tb--;
                if (m_tb == 0) begin m_mode = 3; m_win = 1'b1; end
              end
              if (m_mode == 2 && pb) begin m_mode = 1; m_el = 0; end
            end
          end
        end
        default: if (ps) begin m_mode = 0; m_ta = INIT; m_tb = INIT; end
      endcase
      // Level flips once the last DEB synchronized samples all disagree with it.
      for (int i = 0; i < 3; i++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DEB; j++) if (hist[j][i] == m_db[i]) all_diff = 1'b0;
        nxt_pulse[i] = 1'b0;
        if (all_diff) begin
          m_db[i]      = ~m_db[i];
          nxt_pulse[i] = m_db[i] & m_arm[i];
        end
        if (nsamp >= 2 && !hist[1][i]) m_arm[i] = 1'b1;
      end
      m_pulse = nxt_pulse;
      for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = btns;
      nsamp++;
    end
  end

  always @(negedge clk) begin
    check("en", en, (m_mode == 3) ? 1 : 0);
    check("win", win, m_win);
    check("time_a", time_a, m_ta);
    check("time_b", time_b, m_tb);
    check("turn", turn, (m_mode == 1) ? 1 : (m_mode == 2) ? 2 : 0);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx, input int hold);
    @(posedge clk); #2;
    btns[idx] = 1'b1;
    repeat (hold) @(posedge clk);
    #2;
    btns[idx] = 1'b0;
  endtask

  task automatic set_btn(input int idx, input bit val);
    @(posedge clk); #2;
    btns[idx] = val;
  endtask

  task automatic wait_turn(input logic [1:0] exp, input int max, input string name);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (turn === exp) break;
    end
    check(name, turn, exp);
  endtask

  initial begin
    int   n_sw;
    logic [1:0] prev;
    rst_n = 1'b0;
    btns  = '0;
    idle(3);
    check("rst_en", en, 0);
    check("rst_turn", turn, 0);
    check("rst_ta", time_a, 3);
    check("rst_tb", time_b, 3);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(4);

    // Two-cycle glitch never survives the debouncer.
    press(0, 2);
    idle(12);
    check("glitch_turn", turn, 0);
    check("glitch_en", en, 0);

    // A times out untouched.
    press(0, 4);
    wait_turn(2'b01, 20, "s2_start");
    repeat (3) @(negedge clk);
    check("s2_ta_n3", time_a, 3);
    @(negedge clk);
    check("s2_ta_n4", time_a, 2);
    repeat (4) @(negedge clk);
    check("s2_ta_n8", time_a, 1);
    repeat (4) @(negedge clk);
    check("s2_en", en, 1);
    check("s2_win", win, 0);
    check("s2_ta_end", time_a, 0);
    check("s2_tb_end", time_b, 3);
    idle(4);
    press(0, 4);
    idle(10);
    check("done_start_en", en, 0);
    check("done_start_ta", time_a, 3);
    check("done_start_tb", time_b, 3);

    // One tick for A, hand over to B, B times out.
    press(0, 4);
    wait_turn(2'b01, 20, "s3_start");
    set_btn(1, 1'b1);
    wait_turn(2'b10, 20, "s3_switch");
    check("s3_ta_frozen", time_a, 2);
    repeat (3) @(negedge clk);
    check("s3_tb_m3", time_b, 3);
    @(negedge clk);
    check("s3_tb_m4", time_b, 2);
    repeat (8) @(negedge clk);
    check("s3_en", en, 1);
    check("s3_win", win, 1);
    check("s3_tb_end", time_b, 0);
    check("s3_ta_end", time_a, 2);
    set_btn(1, 1'b0);
    idle(6);
    press(0, 4);
    idle(10);

    // End-of-turn press lands on the final tick: timeout wins.
    press(0, 4);
    wait_turn(2'b01, 20, "s4_start");
    repeat (6) @(posedge clk);
    #2;
    btns[1] = 1'b1;
    repeat (6) @(negedge clk);
    check("s4_ta_before", time_a, 1);
    check("s4_turn_before", turn, 1);
    @(negedge clk);
    check("s4_en", en, 1);
    check("s4_win", win, 0);
    check("s4_ta", time_a, 0);
    check("s4_turn", turn, 0);
    set_btn(1, 1'b0);
    idle(6);
    press(0, 4);
    idle(10);

    // Holding A for 20 cycles gives a single hand-over.
    press(0, 4);
    wait_turn(2'b01, 20, "s5_start");
    prev = turn;
    n_sw = 0;
    set_btn(1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (turn == 2'b10 && prev != 2'b10) n_sw++;
      prev = turn;
    end
    check("s5_switches", n_sw, 1);
    set_btn(1, 1'b0);
    idle(6);
    check("s5_en", en, 1);
    check("s5_win", win, 1);
    press(0, 4);
    idle(10);
    press(0, 4);
    wait_turn(2'b01, 20, "s5b_start");
    press(2, 4);
    repeat (3) @(negedge clk);
    check("s5b_turn", turn, 1);
    check("s5b_ta", time_a, 2);
    idle(10);
    check("s5b_en", en, 1);
    check("s5b_win", win, 0);

    // Reset in RUN_B, with start held through the release.
    press(0, 4);
    idle(10);
    press(0, 4);
    wait_turn(2'b01, 20, "s6_start");
    press(1, 4);
    wait_turn(2'b10, 20, "s6_switch");
    idle(2);
    @(posedge clk); #2;
    rst_n   = 1'b0;
    btns[0] = 1'b1;
    #1;
    check("s6_rst_en", en, 0);
    check("s6_rst_turn", turn, 0);
    check("s6_rst_ta", time_a, 3);
    check("s6_rst_tb", time_b, 3);
    idle(3);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(15);
    check("s6_held_turn", turn, 0);
    set_btn(0, 1'b0);
    idle(8);
    press(0, 4);
    wait_turn(2'b01, 20, "s6_restart");
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/chess_ctrl.md
CHESS_CTRL -- requirements
Module: chess_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per one-second tick (>=2).
REQ-002 SHALL have parameter DEB_CYCLES, default 1000000, consecutive stable cycles needed to accept a button level change (>=1).
REQ-003 SHALL have parameter INIT_SEC, default 300, per-player starting time in seconds (1..1023).
REQ-004 SHALL have port clk  input  1  system clock; single clock domain, all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port btn_start  input  1  raw start/abort button, asynchronous, active-high.
REQ-007 SHALL have port btn_a  input  1  raw player-A end-of-turn button, asynchronous, active-high.
REQ-008 SHALL have port btn_b  input  1  raw player-B end-of-turn button, asynchronous, active-high.
REQ-009 SHALL have port en  output  1  result-valid flag for the segment display driver; 1 only in DONE.
REQ-010 SHALL have port win  output  1  winner flag; 1 = player A won, 0 = player B won; meaningful only while en=1.
REQ-011 SHALL have port time_a  output  10  player A remaining seconds, unsigned.
REQ-012 SHALL have port time_b  output  10  player B remaining seconds, unsigned.
REQ-013 SHALL have port turn  output  2  2'b00 idle/done, 2'b01 A running, 2'b10 B running.

Function
REQ-014 SHALL pass each button through a 2-FF synchronizer and then a debouncer: debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any mismatch break restarts the count.
REQ-015 SHALL generate a registered one-cycle press pulse per button on each 0->1 transition of its debounced level; holding a button yields exactly one pulse.
REQ-016 SHALL implement FSM states IDLE, RUN_A, RUN_B, DONE; the FSM acts on the clock edge at which a pulse is 1.
REQ-017 IDLE: time_a=time_b=INIT_SEC; start pulse -> RUN_A; a/b pulses ignored.
REQ-018 RUN_A: a pulse -> RUN_B; b pulse ignored; start pulse -> IDLE with both times reloaded.
REQ-019 RUN_B: b pulse -> RUN_A; a pulse ignored; start pulse -> IDLE with both times reloaded.
REQ-020 SHALL count a prescaler 0..TICK_DIV-1 only in RUN_A/RUN_B; it is cleared to 0 on every state change; a tick occurs in the cycle the prescaler equals TICK_DIV-1.
REQ-021 On a tick, the running player's time SHALL decrement by 1; the other player's time is unchanged.
REQ-022 A tick that takes the running time from 1 to 0 SHALL move to DONE on that edge with win = opponent (RUN_A timeout -> win=0, RUN_B timeout -> win=1).
REQ-023 If a tick taking the running time to 0 coincides with that player's end-of-turn pulse, timeout SHALL take priority (DONE, player loses).
REQ-024 If start and a/b pulses coincide in RUN_A/RUN_B, start SHALL take priority; start also outranks timeout.
REQ-025 DONE: en=1, win held, times frozen (loser shows 0); start pulse -> IDLE with reload; a/b pulses ignored.
REQ-026 en, win, turn SHALL be registered, changing on the same edge as the FSM state.
REQ-027 Times SHALL never wrap below 0.

Reset
REQ-028 While rst_n=0: state IDLE, en=0, win=0, turn=2'b00, time_a=time_b=INIT_SEC, prescaler 0, synchronizers/debounced levels/pulses/debounce counters 0.
REQ-029 Reset assertion mid-game SHALL abandon the game immediately; after release the block is in IDLE and needs a fresh start press; a button held through release produces no pulse until released and pressed again.

Verification (TICK_DIV=4, DEB_CYCLES=3, INIT_SEC=3)
REQ-030 Glitch: btn_start high 2 cycles then low -> no pulse, state stays IDLE, turn=00.
REQ-031 Start then no input -> turn=01, time_a 3->2->1->0 at 4-cycle spacing, then en=1, win=0, time_b=3.
REQ-032 Start, one tick, btn_a pressed -> turn=10, time_a=2 frozen, prescaler restarts, time_b decrements; B timeout -> en=1, win=1.
REQ-033 In RUN_A with time_a=1, a pulse on the same edge as the final tick -> DONE, win=0, time_a=0.
REQ-034 Hold btn_a for 20 cycles in RUN_A -> exactly one switch to RUN_B; btn_b pressed in RUN_A -> no change.
REQ-035 rst_n low mid RUN_B -> outputs immediately en=0, turn=00, times=3; start press in DONE -> IDLE, en=0, times reloaded.
